// File: rtl/gpio_in_cond.sv
// gpio_in_cond: 2-flop synchronizer, tick-sampled debounce and sticky rising-edge flags for one input bank.
// Rev 1.0
`default_nettype none

module gpio_in_cond #(
  parameter int WIDTH      = 32,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             clr_evt,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] evt_out,
  output logic             evt_any
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] C_TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_CNT_LAST  = CW'(STABLE_CNT - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic             w_tick;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] evt_q, evt_d;
  logic             any_q, any_d;

  always_comb begin
    w_tick  = (pre_q == C_TICK_LAST);
    pre_d   = w_tick ? '0 : pre_q + PW'(1);
    level_d = level_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (w_tick) begin
        // Any agreeing sample restarts qualification of a pending change.
        if (s2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == C_CNT_LAST) begin
          level_d[i] = s2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    // A rise on the same edge as a clear keeps the flag set.
    evt_d = (evt_q & ~(clr_evt ? clr_mask : '0)) | (level_d & ~level_q);
    any_d = |evt_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      pre_q   <= '0;
      level_q <= '0;
      evt_q   <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= raw_in;
      s2_q    <= s1_q;
      pre_q   <= pre_d;
      level_q <= level_d;
      evt_q   <= evt_d;
      any_q   <= any_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level_out = level_q;
  assign evt_out   = evt_q;
  assign evt_any   = any_q;

endmodule

`default_nettype wire

// File: doc/gpio_in_cond.md
Name: gpio_in_cond

Overview:
- Input conditioner directly upstream of the GPIO peripheral's read ports.
- Takes raw asynchronous board inputs (switches and buttons), then synchronizes and debounces them. The stable levels drive gpI1.
- Captures sticky rising-edge event flags per bit, which drive gpI2. Software clears these flags by writing a mask.
- One instance serves one 32-bit input bank.

Parameters:
- WIDTH, 32, number of input bits.
- TICK_DIV, 50000, clk cycles per debounce sample tick. Must be >= 1.
- STABLE_CNT, 4, consecutive sample ticks a new value must persist before it is accepted. Must be >= 1.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronous to clk upstream.
- raw_in  in  WIDTH  unsynchronized board inputs.
- clr_evt  in  1  one-cycle strobe that clears event flags selected by clr_mask.
- clr_mask  in  WIDTH  bit i = 1 clears evt_out[i] when clr_evt = 1.
- level_out  out  WIDTH  debounced stable level, registered (feeds gpI1).
- evt_out  out  WIDTH  sticky rising-edge flags, registered (feeds gpI2).
- evt_any  out  1  OR-reduction of evt_out, registered (same-cycle as evt_out).

Behaviour:
- Reset (rst = 0, async):
  - sync stages, level_out, evt_out, evt_any, per-bit counters and prescaler all go to 0.
  - Outputs stay 0 while rst = 0.
- Synchronizer: 2-flop chain per bit, raw_in -> s1 -> s2. s2 is the only raw-derived signal used downstream.
- Prescaler:
  - Counter 0..TICK_DIV-1, increments every clk and wraps to 0.
  - tick = (cnt == TICK_DIV-1), combinational.
  - TICK_DIV = 1 gives tick every cycle.
  - The first tick after reset release occurs on the TICK_DIV-th clk edge.
- Per-bit debounce counter:
  - Width clog2(STABLE_CNT+1), updated only on tick.
  - If s2[i] == level_out[i]: counter <= 0.
  - Else if counter == STABLE_CNT-1: level_out[i] <= s2[i], counter <= 0.
  - Else: counter <= counter+1.
  - Any tick that samples agreement restarts the count, so a glitch shorter than STABLE_CNT consecutive ticks never changes level_out.
- Latency:
  - A clean raw_in change is visible in s2 after 2 clk edges.
  - level_out updates on the STABLE_CNT-th tick that samples the new s2.
  - Total is between 2+(STABLE_CNT-1)*TICK_DIV+1 and 2+STABLE_CNT*TICK_DIV clk edges.
- Event capture:
  - evt_out[i] sets on the clk edge where level_out[i] transitions 0->1 (computed from the next-state of level_out, so same edge as the level update).
  - Falling transitions never set flags.
  - Flags remain set until cleared.
- Clear:
  - On a clk edge with clr_evt = 1, evt_out[i] <= 0 for every i with clr_mask[i] = 1.
  - clr_mask is ignored when clr_evt = 0.
  - Simultaneous set and clear on the same bit in the same cycle: set wins (flag = 1), so no event is lost.
  - Bits not in the mask are unaffected.
- evt_any: registered OR of the next-state evt_out, so it always equals |evt_out.
- Bits are fully independent; only the prescaler is shared.
- Reset mid-debounce discards the partial count and the pending level. After release the block re-qualifies from 0.
- No combinational path from any input to any output.

Test Plan (TICK_DIV=4, STABLE_CNT=3, WIDTH=32 unless stated):
- Reset: hold rst = 0 with raw_in = 32'hFFFF_FFFF and toggle clk -> level_out = 0, evt_out = 0, evt_any = 0 throughout. Pulse rst low asynchronously mid-cycle -> outputs clear without a clk edge.
- Clean press: raw_in = 32'h0000_0001 steady from cycle 0 after reset release.
  - level_out[0] = 1 and evt_out[0] = 1 on the same edge, within cycles 11..14, never earlier.
  - evt_any = 1 on that edge; all other bits stay 0.
- Glitch rejection: raw_in[5] high for 6 clk cycles then low -> level_out[5] and evt_out[5] stay 0 for 40 cycles.
- Release and clear: after bit 0 is stable high with its flag set, drive raw_in[0] = 0 -> level_out[0] falls after qualification and evt_out[0] stays 1. Then clr_evt = 1 with clr_mask = 32'h1 for one cycle -> evt_out = 0 and evt_any = 0 on the next edge.
- Set/clear collision: arrange the level_out[3] 0->1 edge to coincide with clr_evt = 1, clr_mask = 32'h8 -> evt_out[3] = 1 after that edge.
- Multi-bit and parameter corners:
  - raw_in = 32'hA5A5_0000 simultaneously -> level_out = 32'hA5A5_0000 and evt_out = 32'hA5A5_0000 on one common edge. Then clr_mask = 32'h0500_0000 -> evt_out = 32'hA0A5_0000.
  - Rerun the clean press with TICK_DIV=1, STABLE_CNT=1 -> level_out updates exactly 3 edges after raw_in changes.
